// File: rtl/sprite_mirror_writer_if.sv
// Bus bundle for sprite_mirror_writer: copy control, source RAM read port and
// destination RAM write port. The writer is the master of both RAM ports.
interface sprite_mirror_writer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24
);
  logic              start;
  logic              flip_h;
  logic              flip_v;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, flip_h, flip_v, src_data,
    output src_addr, dst_we, dst_addr, dst_data, busy, done
  );

  modport slave (
    output start, flip_h, flip_v, src_data,
    input  src_addr, dst_we, dst_addr, dst_data, busy, done
  );
endinterface

// File: rtl/sprite_mirror_writer.sv
// sprite_mirror_writer: copies a SPR_W x SPR_H sprite from a source RAM to a
// destination RAM, optionally mirrored horizontally and/or vertically.
// Source addresses are issued row-major; the destination address is produced
// one stage later so it lines up with the 1-cycle registered RAM read data.
// Destination addressing uses a row-base register stepped by +/-SPR_W and a
// column offset stepped by +/-1, so no multiplier is needed.
module sprite_mirror_writer #(
  parameter int SPR_W    = 30,
  parameter int SPR_H    = 29,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 24,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  sprite_mirror_writer_if.master bus
);

  localparam logic [ADDR_W-1:0] ZERO_L       = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_L        = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_L          = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] X_LAST       = ADDR_W'(SPR_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST       = ADDR_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] SRC_BASE_L   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_BASE_L   = ADDR_W'(DST_BASE);
  // Elaboration-time constant: base of the last destination row.
  localparam logic [ADDR_W-1:0] DST_LAST_ROW = ADDR_W'(DST_BASE + (SPR_H - 1) * SPR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_nxt;
  logic              accept_s, row_end_s, last_s;
  logic              flip_h_r, flip_v_r;
  logic [ADDR_W-1:0] x_r, y_r;
  logic [ADDR_W-1:0] src_addr_r;
  logic [ADDR_W-1:0] dst_row_r, dst_col_r;
  logic [ADDR_W-1:0] dst_addr_r;
  logic              dst_we_r, busy_r, done_r;
  logic [DATA_W-1:0] pass_s;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state_r;
    accept_s  = 1'b0;
    row_end_s = (x_r == X_LAST);
    last_s    = row_end_s && (y_r == Y_LAST);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any copy in progress.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Address counters, write pipeline stage and status flags.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      flip_h_r   <= 1'b0;
      flip_v_r   <= 1'b0;
      x_r        <= ZERO_L;
      y_r        <= ZERO_L;
      src_addr_r <= SRC_BASE_L;
      dst_row_r  <= DST_BASE_L;
      dst_col_r  <= ZERO_L;
      dst_addr_r <= DST_BASE_L;
      dst_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // The write stage trails the read stage by exactly one cycle.
      dst_we_r <= (state_r == RUN);
      if (state_r == RUN) begin
        dst_addr_r <= dst_row_r + dst_col_r;
      end
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_r == DRAIN);

      if (accept_s) begin
        flip_h_r   <= bus.flip_h;
        flip_v_r   <= bus.flip_v;
        x_r        <= ZERO_L;
        y_r        <= ZERO_L;
        src_addr_r <= SRC_BASE_L;
        dst_row_r  <= bus.flip_v ? DST_LAST_ROW : DST_BASE_L;
        dst_col_r  <= bus.flip_h ? X_LAST : ZERO_L;
      end else if ((state_r == RUN) && !last_s) begin
        src_addr_r <= src_addr_r + ONE_L;
        if (row_end_s) begin
          x_r       <= ZERO_L;
          y_r       <= y_r + ONE_L;
          dst_col_r <= flip_h_r ? X_LAST : ZERO_L;
          dst_row_r <= flip_v_r ? (dst_row_r - W_L) : (dst_row_r + W_L);
        end else begin
          x_r       <= x_r + ONE_L;
          dst_col_r <= flip_h_r ? (dst_col_r - ONE_L) : (dst_col_r + ONE_L);
        end
      end
    end
  end

  // Pixel data goes straight from source read data to destination write data.
  assign pass_s       = bus.src_data;
  assign bus.dst_data = pass_s;
  assign bus.src_addr = src_addr_r;
  assign bus.dst_addr = dst_addr_r;
  assign bus.dst_we   = dst_we_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_sprite_mirror_writer.sv
// Testbench for sprite_mirror_writer: source RAM model with registered read,
// destination RAM capture, a write-stream monitor checked against addresses
// computed directly from pixel coordinates, table-driven probes and random runs.
module tb_sprite_mirror_writer;
  localparam int W  = 30;
  localparam int H  = 29;
  localparam int N  = W * H;
  localparam int AW = 15;
  localparam int DW = 24;
  localparam int SB = 0;
  localparam int DB = 0;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sprite_mirror_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sprite_mirror_writer #(
    .SPR_W(W), .SPR_H(H), .ADDR_W(AW), .DATA_W(DW), .SRC_BASE(SB), .DST_BASE(DB)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  logic [DW-1:0] src_mem [0:(1<<AW)-1];
  logic [DW-1:0] dst_mem [0:(1<<AW)-1];
  logic [DW-1:0] src_q;

  // RAM models: registered source read, destination write.
  always @(posedge Clk) begin
    src_q <= src_mem[bus.src_addr];
    if (bus.dst_we) dst_mem[bus.dst_addr] <= bus.dst_data;
  end
  assign bus.src_data = src_q;

  int vectors = 0;
  int miscompares = 0;

  // Expected destination address of the i-th source pixel.
  function automatic logic [AW-1:0] exp_dst(input int i, input bit fh, input bit fv);
    int x, y, xx, yy;
    x  = i % W;
    y  = i / W;
    xx = fh ? (W - 1 - x) : x;
    yy = fv ? (H - 1 - y) : y;
    return AW'(DB + yy * W + xx);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write-stream monitor.
  int wr_cnt, bad_cnt, done_cnt, busy_cnt, we_runs, first_bad;
  logic prev_we = 1'b0;
  bit exp_fh, exp_fv;

  // Compare every write against the coordinate model; count pulses and runs.
  always @(negedge Clk) begin
    if (bus.dst_we === 1'b1) begin
      if ((bus.dst_addr !== exp_dst(wr_cnt, exp_fh, exp_fv)) ||
          (bus.dst_data !== src_mem[SB + (wr_cnt % N)])) begin
        if (bad_cnt == 0) first_bad = wr_cnt;
        bad_cnt++;
      end
      if (prev_we !== 1'b1) we_runs++;
      wr_cnt++;
    end
    prev_we = bus.dst_we;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic clear_counts();
    wr_cnt = 0; bad_cnt = 0; done_cnt = 0; busy_cnt = 0; we_runs = 0; first_bad = -1;
  endtask

  task automatic clear_dst();
    for (int i = 0; i < N; i++) dst_mem[DB + i] = 24'hBADBAD;
  endtask

  // Called at negedge+1: starts a copy and returns in its done cycle.
  task automatic run_copy(input bit fh, input bit fv, input int glitch);
    int c;
    exp_fh = fh;
    exp_fv = fv;
    clear_counts();
    bus.start  = 1'b1;
    bus.flip_h = fh;
    bus.flip_v = fv;
    c = 0;
    do begin
      @(negedge Clk); #1;
      c++;
      if (c == 1) bus.start = 1'b0;
      if (glitch != 0 && c == glitch) begin
        bus.start  = 1'b1;
        bus.flip_h = ~fh;
        bus.flip_v = ~fv;
      end
      if (glitch != 0 && c == glitch + 1) bus.start = 1'b0;
    end while ((bus.done !== 1'b1) && (c < N + 20));
    check("done_latency", c, N + 2);
  endtask

  task automatic finish_checks(input string tag);
    repeat (3) begin @(negedge Clk); #1; end
    check({tag, ".writes"}, wr_cnt, N);
    check({tag, ".bad_pairs"}, bad_cnt, 0);
    if (bad_cnt != 0) $display("  %s first bad write index %0d", tag, first_bad);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".busy_cycles"}, busy_cnt, N + 1);
    check({tag, ".we_runs"}, we_runs, 1);
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++)
      if (dst_mem[exp_dst(i, exp_fh, exp_fv)] !== src_mem[SB + i]) bad++;
    check({tag, ".image"}, bad, 0);
  endtask

  typedef struct {
    bit fh;
    bit fv;
    int addr;
    int exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit have, cur_fh, cur_fv, rfh, rfv;
    int g;

    tbl[0]  = '{1'b1, 1'b0,  29,   0};
    tbl[1]  = '{1'b1, 1'b0,   0,  29};
    tbl[2]  = '{1'b1, 1'b0, 869, 840};
    tbl[3]  = '{1'b1, 1'b0, 840, 869};
    tbl[4]  = '{1'b0, 1'b1, 840,   0};
    tbl[5]  = '{1'b0, 1'b1,   0, 840};
    tbl[6]  = '{1'b0, 1'b1, 869,  29};
    tbl[7]  = '{1'b1, 1'b1, 869,   0};
    tbl[8]  = '{1'b1, 1'b1,   0, 869};
    tbl[9]  = '{1'b0, 1'b0,   0,   0};
    tbl[10] = '{1'b0, 1'b0, 869, 869};
    tbl[11] = '{1'b0, 1'b0, 431, 431};

    bus.start = 1'b0; bus.flip_h = 1'b0; bus.flip_v = 1'b0;
    for (int i = 0; i < N; i++) src_mem[SB + i] = DW'(i);
    clear_dst();
    clear_counts();

    // Reset held for 3 edges.
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check("rst.dst_we", int'(bus.dst_we), 0);
    check("rst.src_addr", int'(bus.src_addr), SB);
    check("rst.dst_addr", int'(bus.dst_addr), DB);
    Reset_n = 1'b1;
    @(negedge Clk); #1;

    // Table-driven probes; one copy per distinct flip setting.
    have = 1'b0; cur_fh = 1'b0; cur_fv = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!have || tbl[k].fh != cur_fh || tbl[k].fv != cur_fv) begin
        clear_dst();
        run_copy(tbl[k].fh, tbl[k].fv, 0);
        finish_checks($sformatf("copy_h%0d_v%0d", tbl[k].fh, tbl[k].fv));
        check_image($sformatf("copy_h%0d_v%0d", tbl[k].fh, tbl[k].fv));
        have = 1'b1; cur_fh = tbl[k].fh; cur_fv = tbl[k].fv;
      end
      check($sformatf("probe%0d.dst[%0d]", k, tbl[k].addr), int'(dst_mem[tbl[k].addr]), tbl[k].exp);
    end

    // start with different flips mid-copy is ignored.
    clear_dst();
    run_copy(1'b1, 1'b0, 300);
    finish_checks("busy_start");
    check_image("busy_start");

    // start in the done cycle is accepted.
    clear_dst();
    run_copy(1'b0, 1'b0, 0);
    run_copy(1'b1, 1'b1, 0);
    finish_checks("done_cycle_start");
    check_image("done_cycle_start");

    // Reset after 100 writes abandons the copy.
    clear_dst();
    exp_fh = 1'b0; exp_fv = 1'b0;
    clear_counts();
    bus.start = 1'b1; bus.flip_h = 1'b0; bus.flip_v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk); #1;
      bus.start = 1'b0;
      if (wr_cnt >= 100) break;
    end
    check("abort.writes_before", wr_cnt, 100);
    Reset_n = 1'b0;
    @(negedge Clk); #1;
    check("abort.dst_we", int'(bus.dst_we), 0);
    check("abort.busy", int'(bus.busy), 0);
    check("abort.src_addr", int'(bus.src_addr), SB);
    Reset_n = 1'b1;
    repeat (5) begin @(negedge Clk); #1; end
    check("abort.done_pulses", done_cnt, 0);
    check("abort.writes_after", wr_cnt, 100);
    check("abort.busy_idle", int'(bus.busy), 0);
    run_copy(1'b0, 1'b1, 0);
    finish_checks("after_abort");
    check_image("after_abort");

    // Random pixel data, flips and ignored mid-copy starts.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) src_mem[SB + i] = DW'($urandom);
      rfh = 1'($urandom_range(0, 1));
      rfv = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, N)) : 0;
      clear_dst();
      run_copy(rfh, rfv, g);
      finish_checks($sformatf("rand%0d", r));
      check_image($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
